dut_stream_buf: RTL
===================

Name: dut_stream_buf

Overview:
- Parametrised successor to the current 8-bit rxd/rx_dv -> txd/tx_en pass-through DUT.
- Generalised data width; adds a DEPTH-word elastic buffer, valid/ready backpressure on both sides, and a selectable drop-on-full mode with a saturating drop counter.
- Sits between the rx agent interface and the tx monitor interface as the new DUT under the UVM env.
- Empty-buffer latency equals the current block's: 1 cycle.

Parameters:
- DATA_W, 8, width of rxd/txd.
- DEPTH, 16, FIFO entries; power of 2, >= 2.
- DROP_ON_FULL, 0; 0 = backpressure via rx_rdy, 1 = rx_rdy held 1 and words arriving while full are dropped and counted.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  DATA_W  receive data.
- rx_dv  input  1  rxd valid.
- rx_rdy  output  1  block can accept a word this cycle.
- txd  output  DATA_W  transmit data.
- tx_en  output  1  txd valid.
- tx_rdy  input  1  sink accepts txd this cycle.
- fill  output  $clog2(DEPTH+2)  words held (FIFO count + output register occupancy), 0..DEPTH+1.
- drop_cnt  output  16  dropped words, saturating.

Behaviour:
- Reset (rst_n low, async): txd=0, tx_en=0, fill=0, drop_cnt=0, rx_rdy=0, FIFO pointers=0. rx_rdy rises on the first clk edge after rst_n deasserts.
- Accept: a word is accepted on a clk edge when rx_dv && rx_rdy (backpressure mode), or rx_dv && !fifo_full (drop mode).
- Output register (tx_en/txd): the single output stage.
  - It is "free" when tx_en=0 or tx_rdy=1.
  - When free and FIFO non-empty: load FIFO head.
  - Else when free, FIFO empty and a word is accepted: load rxd directly (bypass), giving tx_en=1 one cycle after rx_dv.
  - Else when free: tx_en <= 0.
  - Otherwise an accepted word is pushed into the FIFO.
- While tx_en && !tx_rdy, txd and tx_en hold stable. No word is lost or reordered.
- Ordering: strict FIFO. An accepted word never overtakes an older one. Bypass applies only when FIFO empty.
- Simultaneous push and pop with FIFO non-empty: head moves to the output register, the new word is pushed, count unchanged.
- rx_rdy: registered.
  - Backpressure mode: rx_rdy <= (next FIFO count < DEPTH).
  - Drop mode: rx_rdy <= 1 after reset.
  - rx_rdy never depends combinationally on tx_rdy.
- Full (backpressure mode): rx_rdy=0. rx_dv while rx_rdy=0 is not accepted; the sender holds. drop_cnt stays 0.
- Full (drop mode): rx_dv with FIFO count == DEPTH at the edge drops the word and increments drop_cnt. A pop in the same cycle does not rescue the word.
- drop_cnt saturates at 16'hFFFF and never wraps.
- fill: registered, updated each edge. Maximum DEPTH+1 (FIFO full plus output register occupied).
- Pointers: $clog2(DEPTH) bits, natural wrap. Full/empty come from a $clog2(DEPTH)+1-bit count.
- Reset mid-operation: all buffered words are discarded immediately; tx_en drops asynchronously.
- X on rxd while rx_dv=0 must not propagate into the FIFO or txd.

Decomposition:
- Package dut_stream_pkg:
  - DROP_CNT_W=16 and DROP_CNT_MAX.
  - Mode enum stream_mode_e {MODE_BACKPRESSURE, MODE_DROP}, mapped to DROP_ON_FULL.
  - Default DATA_W/DEPTH constants shared with the UVM env.
- Sub-module dut_sync_fifo(DATA_W, DEPTH): push/pop/full/empty/count, single clock, async active-low reset.
- dut_stream_buf contains the bypass/output-register control, rx_rdy, fill and drop counter.

Test Plan:
- Reset then single word: rxd=8'hA5, rx_dv=1 for 1 cycle, tx_rdy=1 -> tx_en=1, txd=8'hA5 exactly 1 cycle later; fill 1 then 0; rx_rdy=1 from first edge after reset.
- Stream with sink stalled: tx_rdy=0, push 0x00..0x11 with rx_dv=1 held (DEPTH=16, backpressure) -> 17 words accepted (0x00..0x10); rx_rdy=0 at fill=17; 0x11 held by sender; tx_rdy=1 then drains 0x00..0x11 in order, no gaps while tx_rdy=1.
- Backpressure during output hold: tx_en=1, txd=0x03, tx_rdy=0 for 5 cycles -> txd stays 0x03, tx_en stays 1; next cycle with tx_rdy=1 transfers 0x03, then 0x04 follows.
- Drop mode (DROP_ON_FULL=1): tx_rdy=0, push 20 words 0x00..0x13 -> drop_cnt=3, 0x11..0x13 lost; drain yields 0x00..0x10. Force drop_cnt to 0xFFFE, drop 3 more -> reads 0xFFFF.
- Simultaneous push/pop at full: FIFO count=16 in drop mode, tx_rdy=1 and rx_dv=1 same cycle -> incoming word dropped, drop_cnt+1, fill 17->16.
- Reset mid-stream: rst_n=0 with fill=9 and tx_en=1 -> tx_en=0, fill=0 immediately (async), rx_rdy=0; after release the first new word appears 1 cycle later with no stale data.

Source files
------------

// File: rtl/dut_stream_buf_pkg.sv
// Shared constants and types for the dut_stream_buf elastic buffer and its env.
// The UVM env picks up the default widths from here as well.
package dut_stream_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    localparam int                    DROP_CNT_W   = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic {
        MODE_BACKPRESSURE = 1'b0,
        MODE_DROP         = 1'b1
    } stream_mode_e;

    function automatic stream_mode_e mode_from_param(input int drop_on_full);
        return (drop_on_full != 0) ? MODE_DROP : MODE_BACKPRESSURE;
    endfunction

endpackage

// File: rtl/dut_sync_fifo.sv
// Single-clock FIFO with occupancy count; the count (one bit wider than the
// pointers) alone decides full and empty, so the pointers wrap naturally.
module dut_sync_fifo
    import dut_stream_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; the count guards every read, and
    // leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dut_stream_buf.sv
// Elastic stream buffer: FIFO plus one output register with an empty-FIFO
// bypass, registered rx_rdy, occupancy reporting and a saturating drop counter.
module dut_stream_buf
    import dut_stream_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int DROP_ON_FULL = 0,
    localparam int FILL_W      = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     rxd,
    input  logic                  rx_dv,
    output logic                  rx_rdy,
    output logic [DATA_W-1:0]     txd,
    output logic                  tx_en,
    input  logic                  tx_rdy,
    output logic [FILL_W-1:0]     fill,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam stream_mode_e MODE  = mode_from_param(DROP_ON_FULL);
    localparam int           CNT_W = $clog2(DEPTH) + 1;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic              out_free;
    logic              accept;
    logic              dropped;
    logic              bypass;
    logic              tx_en_next;

    dut_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (rxd),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal gets a value on every path through this block, so no
    // latch is inferred.
    always_comb begin
        out_free = !tx_en || tx_rdy;
        accept   = 1'b0;
        dropped  = 1'b0;
        if (MODE == MODE_DROP) begin
            // A pop in the same cycle does not make room for a word arriving at full.
            accept  = rx_dv && !fifo_full;
            dropped = rx_dv && fifo_full;
        end else begin
            accept  = rx_dv && rx_rdy;
        end
        fifo_pop   = out_free && !fifo_empty;
        bypass     = out_free && fifo_empty && accept;
        fifo_push  = accept && !bypass;
        tx_en_next = out_free ? (fifo_pop || bypass) : 1'b1;
        count_next = fifo_count;
        if (fifo_push && !fifo_pop) count_next = fifo_count + CNT_W'(1);
        if (fifo_pop && !fifo_push) count_next = fifo_count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd      <= '0;
            tx_en    <= 1'b0;
            rx_rdy   <= 1'b0;
            fill     <= '0;
            drop_cnt <= '0;
        end else begin
            tx_en <= tx_en_next;
            if (fifo_pop) begin
                txd <= fifo_head;
            end else if (bypass) begin
                txd <= rxd;
            end
            // Looks only at the FIFO's next count, never at tx_rdy directly.
            rx_rdy <= (MODE == MODE_DROP) ? 1'b1 : (count_next < CNT_W'(DEPTH));
            fill   <= FILL_W'(count_next) + FILL_W'(tx_en_next);
            if (dropped && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule
